serial_word_deser: RTL and testbench
====================================

Name: serial_word_deser

Overview:
- Downstream consumer of the dff stage: takes the registered serial bit stream and its qualifier, and assembles bits into WIDTH-bit parallel words.
- Words are presented on a valid/ready output with a one-entry holding register.
- Drops are detected and flagged when the consumer stalls too long.
- Sits between the bit-level flop stage and word-level logic.

Parameters:
- WIDTH, 8, data bits per word (min 2).
- CNT_W, $clog2(WIDTH+2), width of bit_cnt_o (covers the parity bit when enabled).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- bit_valid_i  input  1  bit_i is sampled on this rising edge.
- bit_i  input  1  serial data bit, LSB-first.
- flush_i  input  1  discard the partially assembled word.
- word_ready_i  input  1  consumer accepts word_o.
- word_valid_o  output  1  word_o holds a complete word.
- word_o  output  WIDTH  assembled word.
- parity_err_o  output  1  parity mismatch for word_o (valid with word_valid_o).
- bit_cnt_o  output  CNT_W  bits accepted into the current frame.
- overflow_o  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high; it acts immediately, independent of clk.
  - On assertion, clear every output, the shift register and the FSM to 0 / OUT_EMPTY, including mid-word.
- Bit assembly:
  - When bit_valid_i=1 and flush_i=0, shift bit_i in and increment bit_cnt_o.
  - The k-th accepted bit of a frame lands in word bit k.
  - Gaps in bit_valid_i are allowed; shifter and count hold during gaps.
- Frame length: FRAME = WIDTH, or WIDTH+1 with PARITY_CHK_EN.
- Frame completion:
  - On the edge that accepts bit FRAME, bit_cnt_o wraps to 0.
  - The completed word is offered to the output register on that same edge.
- Output FSM, states OUT_EMPTY and OUT_FULL:
  - OUT_EMPTY + completion: load word_o and go to OUT_FULL. word_valid_o rises in the cycle after the last bit is sampled (latency 1).
  - OUT_FULL + word_ready_i=1, no completion: go to OUT_EMPTY; word_valid_o falls on that edge.
  - OUT_FULL + word_ready_i=1 + completion on the same edge: load the new word and stay in OUT_FULL. word_valid_o stays high without a bubble; no overflow.
  - OUT_FULL + word_ready_i=0 + completion: drop the new word, set overflow_o=1, keep word_o unchanged.
- Output stability: word_o and parity_err_o are stable while word_valid_o=1 and word_ready_i=0.
- word_ready_i while OUT_EMPTY: ignored.
- flush_i:
  - Clears bit_cnt_o and the partial shifter on the next edge.
  - Clears overflow_o on the next edge.
  - Has priority over a simultaneous bit_valid_i; that bit is discarded.
  - Does not touch the output register or its FSM.
- overflow_o clears only on reset or flush_i.

Optional Feature:
- Macro: SERIAL_WORD_DESER_PARITY_CHK_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - parity_err_o = XOR of all WIDTH+1 frame bits, loaded with word_o.
  - The parity bit is not stored in word_o.
  - The word is delivered even when parity_err_o=1.
- Undefined:
  - Frame is WIDTH bits.
  - parity_err_o is tied to 0; the port is still present.

Test Plan (WIDTH=8):
- Basic word: send 0xA5 LSB-first (1,0,1,0,0,1,0,1) on consecutive cycles, word_ready_i=1.
  - word_valid_o=1 for exactly one cycle, starting the cycle after bit 8.
  - word_o=0xA5, bit_cnt_o back to 0.
- Gapped input: same 0xA5 with bit_valid_i high every other cycle.
  - Identical word_o=0xA5.
  - bit_cnt_o holds during the gaps.
- Backpressure and overflow: word_ready_i=0, send 0x3C then 0xC3.
  - word_o holds 0x3C.
  - overflow_o=1 after the 8th bit of 0xC3.
  - Then raise word_ready_i: 0x3C is accepted once, word_valid_o=0, overflow_o stays 1 until flush_i.
- Drain/complete collision: hold 0x12 with word_ready_i=0, send 0x34, and raise word_ready_i on the edge of 0x34's 8th bit.
  - word_o goes 0x12 -> 0x34 with word_valid_o continuously 1.
  - overflow_o=0.
- Flush and async reset:
  - After 5 bits, pulse flush_i together with bit_valid_i: bit_cnt_o=0; a following 0x0F arrives intact.
  - After 3 bits, assert reset between clock edges: bit_cnt_o=0, word_valid_o=0 immediately, with no clk edge.
- Parity (macro defined):
  - Send 0xA5 + parity bit 0: parity_err_o=0.
  - Send 0xA5 + parity bit 1: word_o=0xA5 with parity_err_o=1.

Source files
------------

// File: rtl/serial_word_deser.sv
// Serial-to-parallel word assembler with a one-entry valid/ready output register.
// Define SERIAL_WORD_DESER_PARITY_CHK_EN to append an even-parity bit to every frame.
module serial_word_deser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    input  logic             flush_i,
    input  logic             word_ready_i,
    output logic             word_valid_o,
    output logic [WIDTH-1:0] word_o,
    output logic             parity_err_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             overflow_o
);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

`ifdef SERIAL_WORD_DESER_PARITY_CHK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

    out_state_t       state;
    out_state_t       state_next;
    logic [FRAME-1:0] shreg;
    logic [FRAME-1:0] frame_next;
    logic             accept;
    logic             complete;
    logic             load_word;
    logic             set_overflow;

    // Right-shifting shifter: after FRAME accepted bits, frame bit k sits at index k.
    assign frame_next = {bit_i, shreg[FRAME-1:1]};
    assign accept     = bit_valid_i & ~flush_i;
    assign complete   = accept && (bit_cnt_o == LAST_IDX);

    // NOTE: every register uses non-blocking assignment so all flops update from
    // the same pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt_o <= '0;
        end else if (flush_i) begin
            shreg     <= '0;
            bit_cnt_o <= '0;
        end else if (accept) begin
            if (complete) begin
                shreg     <= '0;
                bit_cnt_o <= '0;
            end else begin
                shreg     <= frame_next;
                bit_cnt_o <= bit_cnt_o + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: all outputs of this block get a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        load_word    = 1'b0;
        set_overflow = 1'b0;
        unique case (state)
            OUT_EMPTY: begin
                if (complete) begin
                    load_word  = 1'b1;
                    state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (complete) begin
                    // A completion is only taken if the held word drains on the same edge.
                    if (word_ready_i) begin
                        load_word = 1'b1;
                    end else begin
                        set_overflow = 1'b1;
                    end
                end else if (word_ready_i) begin
                    state_next = OUT_EMPTY;
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    assign word_valid_o = (state == OUT_FULL);

    // NOTE: the output register and shifter are ordinary flops, not a memory
    // array, so they take the reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_o <= '0;
        end else if (load_word) begin
            word_o <= frame_next[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o <= 1'b0;
        end else if (set_overflow) begin
            overflow_o <= 1'b1;
        end
    end

`ifdef SERIAL_WORD_DESER_PARITY_CHK_EN
    // Even parity over data plus parity bit: any odd count of ones flags an error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_o <= 1'b0;
        end else if (load_word) begin
            parity_err_o <= ^frame_next;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed self-checking bench for serial_word_deser (WIDTH=8).
// Parity scenarios run only when SERIAL_WORD_DESER_PARITY_CHK_EN is defined.
module tb_serial_word_deser;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 2);

    logic             clk;
    logic             reset;
    logic             bit_valid;
    logic             bit_d;
    logic             flush;
    logic             word_ready;
    logic             word_valid;
    logic [WIDTH-1:0] word;
    logic             parity_err;
    logic [CNT_W-1:0] bit_cnt;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    serial_word_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bit_valid_i  (bit_valid),
        .bit_i        (bit_d),
        .flush_i      (flush),
        .word_ready_i (word_ready),
        .word_valid_o (word_valid),
        .word_o       (word),
        .parity_err_o (parity_err),
        .bit_cnt_o    (bit_cnt),
        .overflow_o   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_d     = b;
        tick();
        bit_valid = 1'b0;
        bit_d     = 1'b0;
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1; bit_valid = 1'b0; bit_d = 1'b0; flush = 1'b0; word_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({word_valid, word, parity_err, bit_cnt, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b word=%h perr=%b cnt=%0d ovf=%b, want all 0",
                     word_valid, word, parity_err, bit_cnt, overflow);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send_bits(8'hA5, 7);
        checks++;
        if (word_valid !== 1'b0 || bit_cnt !== CNT_W'(7)) begin
            failures++;
            $display("FAIL basic_pre: got valid=%b cnt=%0d, want valid=0 cnt=7", word_valid, bit_cnt);
        end
        send_bit(1'b1);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'hA5 || bit_cnt !== '0) begin
            failures++;
            $display("FAIL basic_word: got valid=%b word=%h cnt=%0d, want valid=1 word=a5 cnt=0",
                     word_valid, word, bit_cnt);
        end
        tick();
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_one_cycle: got valid=%b, want 0", word_valid);
        end
    endtask

    task automatic test_gapped();
        logic [WIDTH-1:0] w;
        w = 8'hA5;
        word_ready = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(w[i]);
            tick();
            checks++;
            if (bit_cnt !== CNT_W'((i + 1) % WIDTH)) begin
                failures++;
                $display("FAIL gapped_hold_%0d: got cnt=%0d, want %0d", i, bit_cnt, (i + 1) % WIDTH);
            end
            if (i == WIDTH - 2) begin
                send_bit(w[WIDTH-1]);
                checks++;
                if (word_valid !== 1'b1 || word !== 8'hA5) begin
                    failures++;
                    $display("FAIL gapped_word: got valid=%b word=%h, want valid=1 word=a5",
                             word_valid, word);
                end
                tick();
                checks++;
                if (word_valid !== 1'b0 || bit_cnt !== '0) begin
                    failures++;
                    $display("FAIL gapped_drain: got valid=%b cnt=%0d, want valid=0 cnt=0",
                             word_valid, bit_cnt);
                end
                break;
            end
        end
    endtask

    task automatic test_overflow();
        word_ready = 1'b0;
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 7);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h3C || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pre: got valid=%b word=%h ovf=%b, want valid=1 word=3c ovf=0",
                     word_valid, word, overflow);
        end
        send_bit(1'b1);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h3C || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop: got valid=%b word=%h ovf=%b, want valid=1 word=3c ovf=1",
                     word_valid, word, overflow);
        end
        word_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (word_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got valid=%b ovf=%b, want valid=0 ovf=1", word_valid, overflow);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_flush_clear: got ovf=%b, want 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b0;
        send_bits(8'h12, 8);
        send_bits(8'h34, 7);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h12) begin
            failures++;
            $display("FAIL b2b_hold: got valid=%b word=%h, want valid=1 word=12", word_valid, word);
        end
        word_ready = 1'b1;
        send_bit(1'b0);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h34 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_swap: got valid=%b word=%h ovf=%b, want valid=1 word=34 ovf=0",
                     word_valid, word, overflow);
        end
        tick();
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got valid=%b, want 0", word_valid);
        end
    endtask

    task automatic test_flush();
        word_ready = 1'b1;
        send_bits(8'hFF, 5);
        checks++;
        if (bit_cnt !== CNT_W'(5)) begin
            failures++;
            $display("FAIL flush_pre: got cnt=%0d, want 5", bit_cnt);
        end
        flush = 1'b1;
        send_bit(1'b1);
        flush = 1'b0;
        checks++;
        if (bit_cnt !== '0 || word_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: got cnt=%0d valid=%b, want cnt=0 valid=0", bit_cnt, word_valid);
        end
        send_bits(8'h0F, 8);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'h0F || parity_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_next_word: got valid=%b word=%h perr=%b, want valid=1 word=0f perr=0",
                     word_valid, word, parity_err);
        end
        tick();
    endtask

    task automatic test_async_reset();
        word_ready = 1'b0;
        send_bits(8'h55, 8);
        send_bits(8'h07, 3);
        checks++;
        if (word_valid !== 1'b1 || bit_cnt !== CNT_W'(3)) begin
            failures++;
            $display("FAIL areset_pre: got valid=%b cnt=%0d, want valid=1 cnt=3", word_valid, bit_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bit_cnt !== '0 || word_valid !== 1'b0 || word !== '0) begin
            failures++;
            $display("FAIL areset_immediate: got cnt=%0d valid=%b word=%h, want all 0",
                     bit_cnt, word_valid, word);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

`ifdef SERIAL_WORD_DESER_PARITY_CHK_EN
    task automatic test_parity();
        word_ready = 1'b1;
        send_bits(8'hA5, 8);
        send_bit(1'b0);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'hA5 || parity_err !== 1'b0 || bit_cnt !== '0) begin
            failures++;
            $display("FAIL parity_ok: got valid=%b word=%h perr=%b cnt=%0d, want 1 a5 0 0",
                     word_valid, word, parity_err, bit_cnt);
        end
        send_bits(8'hA5, 8);
        send_bit(1'b1);
        checks++;
        if (word_valid !== 1'b1 || word !== 8'hA5 || parity_err !== 1'b1) begin
            failures++;
            $display("FAIL parity_err: got valid=%b word=%h perr=%b, want 1 a5 1",
                     word_valid, word, parity_err);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef SERIAL_WORD_DESER_PARITY_CHK_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
